onehot_decoder_seq: RTL and testbench

- Parametrised, registered binary-to-one-hot decoder. Generalises the 3-to-8 combinational decoder to SEL_W select bits with 2**SEL_W outputs.
- Adds a load handshake and an auto-scan mode that walks the active output through all positions, with a programmable dwell per position.
- Drives downstream row/column selects, LED/segment strobes and bank enables. Output is glitch-free because it is registered.

---
 rtl/onehot_decoder_pkg.sv | 21 ++
 rtl/onehot_decoder_seq_dwell_counter.sv | 41 ++++
 rtl/onehot_decoder_seq.sv | 132 +++++++++++++
 tb/tb_onehot_decoder_seq.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/onehot_decoder_pkg.sv
// Shared types, constants and helpers for onehot_decoder_seq.
// Helpers are sized for the largest supported select width; callers cast the result down to their own width.
package onehot_decoder_pkg;

  localparam int unsigned MAX_SEL_W = 8;
  localparam int unsigned MAX_OUT_W = 2 ** MAX_SEL_W;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIRECT,
    ST_SCAN
  } state_e;

  function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] sel);
    onehot = MAX_OUT_W'(1) << sel;
  endfunction

endpackage

// File: rtl/onehot_decoder_seq_dwell_counter.sv
// Reloadable dwell down-counter with a zero flag.
// On step it decrements, or reloads the captured dwell when it has reached zero.
module dwell_counter #(
  parameter int unsigned DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_val,
  input  logic               step,
  output logic               zero
);

  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] reload_q;
  logic [DWELL_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (step) begin
      cnt_d = (cnt_q == '0) ? reload_q : cnt_q - DWELL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      reload_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (load) begin
        reload_q <= load_val;
      end
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/onehot_decoder_seq.sv
// Registered binary-to-one-hot decoder with load handshake and auto-scan.
// Optional macro ONEHOT_DECODER_SEQ_SCAN_DIR_EN adds scan_dir for downward scanning.
module onehot_decoder_seq
  import onehot_decoder_pkg::*;
#(
  parameter  int unsigned SEL_W   = 3,
  parameter  int unsigned DWELL_W = 4,
  localparam int unsigned OUT_W   = 2 ** SEL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               load,
`ifdef ONEHOT_DECODER_SEQ_SCAN_DIR_EN
  input  logic               scan_dir,
`endif
  output logic               load_ready,
  output logic [OUT_W-1:0]   y,
  output logic               y_valid,
  output logic [SEL_W-1:0]   idx,
  output logic               wrap
);

  state_e             state_q;
  logic [OUT_W-1:0]   y_q;
  logic               y_valid_q;
  logic [SEL_W-1:0]   idx_q;
  logic               wrap_q;
  logic               dir_q;

  logic               load_acc;
  logic               scan_load;
  logic               step;
  logic               cnt_zero;
  logic               scan_dir_in;
  logic [OUT_W-1:0]   dec_y;
  logic [OUT_W-1:0]   y_step_d;
  logic [SEL_W-1:0]   idx_step_d;
  logic               wrap_step_d;

`ifdef ONEHOT_DECODER_SEQ_SCAN_DIR_EN
  assign scan_dir_in = scan_dir;
`else
  assign scan_dir_in = 1'b0;
`endif

  assign load_ready = en & (state_q != ST_SCAN);
  assign load_acc   = en & load & load_ready;
  assign scan_load  = load_acc & (mode == MODE_SCAN);
  assign step       = en & (state_q == ST_SCAN);
  assign dec_y      = OUT_W'(onehot(MAX_SEL_W'(sel)));

  // Next scan position; wrap is flagged on the step that crosses the index boundary.
  always_comb begin
    y_step_d    = y_q;
    idx_step_d  = idx_q;
    wrap_step_d = 1'b0;
    if (dir_q) begin
      y_step_d    = {y_q[0], y_q[OUT_W-1:1]};
      idx_step_d  = idx_q - SEL_W'(1);
      wrap_step_d = (idx_q == '0);
    end else begin
      y_step_d    = {y_q[OUT_W-2:0], y_q[OUT_W-1]};
      idx_step_d  = idx_q + SEL_W'(1);
      wrap_step_d = (idx_q == '1);
    end
  end

  dwell_counter #(
    .DWELL_W(DWELL_W)
  ) u_dwell (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (scan_load),
    .load_val(dwell),
    .step    (step),
    .zero    (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      idx_q     <= '0;
      wrap_q    <= 1'b0;
      dir_q     <= 1'b0;
    end else if (!en) begin
      state_q   <= ST_IDLE;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DIRECT: begin
          wrap_q <= 1'b0;
          if (load) begin
            y_q       <= dec_y;
            idx_q     <= sel;
            y_valid_q <= 1'b1;
            dir_q     <= scan_dir_in;
            state_q   <= (mode == MODE_SCAN) ? ST_SCAN : ST_DIRECT;
          end
        end
        ST_SCAN: begin
          if (cnt_zero) begin
            y_q    <= y_step_d;
            idx_q  <= idx_step_d;
            wrap_q <= wrap_step_d;
          end else begin
            wrap_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          y_q       <= '0;
          y_valid_q <= 1'b0;
          wrap_q    <= 1'b0;
        end
      endcase
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign idx     = idx_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Directed scoreboard bench for onehot_decoder_seq (SEL_W=3 and SEL_W=4 instances).
// Honours ONEHOT_DECODER_SEQ_SCAN_DIR_EN for the downward-scan case.
module tb_onehot_decoder_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       en3, mode3, load3;
  logic [2:0] sel3;
  logic [3:0] dwell3;
  logic       lr3, yv3, wrap3;
  logic [7:0] y3;
  logic [2:0] idx3;

  logic        en4, mode4, load4;
  logic [3:0]  sel4;
  logic [3:0]  dwell4;
  logic        lr4, yv4, wrap4;
  logic [15:0] y4;
  logic [3:0]  idx4;

`ifdef ONEHOT_DECODER_SEQ_SCAN_DIR_EN
  logic dir3, dir4;
`endif

  onehot_decoder_seq #(.SEL_W(3), .DWELL_W(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en3), .mode(mode3), .sel(sel3), .dwell(dwell3),
    .load(load3),
`ifdef ONEHOT_DECODER_SEQ_SCAN_DIR_EN
    .scan_dir(dir3),
`endif
    .load_ready(lr3), .y(y3), .y_valid(yv3), .idx(idx3), .wrap(wrap3)
  );

  onehot_decoder_seq #(.SEL_W(4), .DWELL_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en4), .mode(mode4), .sel(sel4), .dwell(dwell4),
    .load(load4),
`ifdef ONEHOT_DECODER_SEQ_SCAN_DIR_EN
    .scan_dir(dir4),
`endif
    .load_ready(lr4), .y(y4), .y_valid(yv4), .idx(idx4), .wrap(wrap4)
  );

  typedef struct {
    string       tag;
    logic        big;
    logic [15:0] y;
    logic        yv;
    logic [3:0]  idx;
    logic        wrap;
    logic        lr;
  } exp_t;

  exp_t        sbq[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic push(input string tag, input logic big, input logic [15:0] y,
                      input logic yv, input logic [3:0] idx, input logic wrap, input logic lr);
    exp_t e;
    e.tag = tag; e.big = big; e.y = y; e.yv = yv; e.idx = idx; e.wrap = wrap; e.lr = lr;
    sbq.push_back(e);
  endtask

  task automatic compare_head();
    exp_t        e;
    logic [22:0] obs;
    logic [22:0] expv;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: no expectation queued at time %0t", $time);
      return;
    end
    e    = sbq.pop_front();
    obs  = e.big ? {y4, yv4, idx4, wrap4, lr4} : {8'h00, y3, yv3, 1'b0, idx3, wrap3, lr3};
    expv = {e.y, e.yv, e.idx, e.wrap, e.lr};
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got y=%h v=%b idx=%0d wrap=%b rdy=%b, expected y=%h v=%b idx=%0d wrap=%b rdy=%b",
             e.tag, obs[22:7], obs[6], obs[5:2], obs[1], obs[0],
             e.y, e.yv, e.idx, e.wrap, e.lr);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    compare_head();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq4[6];
    int unsigned k;
    rst_n = 1'b0;
    en3 = 1'b1; mode3 = 1'b0; load3 = 1'b0; sel3 = '0; dwell3 = '0;
    en4 = 1'b1; mode4 = 1'b0; load4 = 1'b0; sel4 = '0; dwell4 = '0;
`ifdef ONEHOT_DECODER_SEQ_SCAN_DIR_EN
    dir3 = 1'b0; dir4 = 1'b0;
`endif

    // Reset held two clocks
    push("reset0", 1'b0, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b1); tick();
    push("reset1", 1'b0, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b1); tick();
    rst_n = 1'b1;

    // Direct decode sweep
    for (int i = 0; i < 8; i++) begin
      load3 = 1'b1; mode3 = 1'b0; sel3 = 3'(i);
      push("direct", 1'b0, 16'(1) << i, 1'b1, 4'(i), 1'b0, 1'b1);
      tick();
    end
    load3 = 1'b0;
    push("direct_hold", 1'b0, 16'h0080, 1'b1, 4'd7, 1'b0, 1'b1); tick();

    // Scan dwell=2 from 6: three cycles per position, wrap on 7->0
    load3 = 1'b1; mode3 = 1'b1; sel3 = 3'd6; dwell3 = 4'd2;
    push("scan2_load", 1'b0, 16'h0040, 1'b1, 4'd6, 1'b0, 1'b0); tick();
    load3 = 1'b0;
    push("scan2", 1'b0, 16'h0040, 1'b1, 4'd6, 1'b0, 1'b0); tick();
    push("scan2", 1'b0, 16'h0040, 1'b1, 4'd6, 1'b0, 1'b0); tick();
    push("scan2", 1'b0, 16'h0080, 1'b1, 4'd7, 1'b0, 1'b0); tick();
    push("scan2", 1'b0, 16'h0080, 1'b1, 4'd7, 1'b0, 1'b0); tick();
    push("scan2", 1'b0, 16'h0080, 1'b1, 4'd7, 1'b0, 1'b0); tick();
    push("scan2_wrap", 1'b0, 16'h0001, 1'b1, 4'd0, 1'b1, 1'b0); tick();
    push("scan2", 1'b0, 16'h0001, 1'b1, 4'd0, 1'b0, 1'b0); tick();
    push("scan2", 1'b0, 16'h0001, 1'b1, 4'd0, 1'b0, 1'b0); tick();
    push("scan2", 1'b0, 16'h0002, 1'b1, 4'd1, 1'b0, 1'b0); tick();

    // Leave scan via enable, then re-enable into idle
    en3 = 1'b0;
    push("en_off", 1'b0, 16'h0000, 1'b0, 4'd1, 1'b0, 1'b0); tick();
    en3 = 1'b1;
    push("idle", 1'b0, 16'h0000, 1'b0, 4'd1, 1'b0, 1'b1); tick();

    // Scan dwell=0 from 0; a direct load mid-scan must be ignored
    load3 = 1'b1; mode3 = 1'b1; sel3 = 3'd0; dwell3 = 4'd0;
    push("scan0_load", 1'b0, 16'h0001, 1'b1, 4'd0, 1'b0, 1'b0); tick();
    load3 = 1'b0;
    for (k = 1; k <= 21; k++) begin
      if (k == 3) begin load3 = 1'b1; mode3 = 1'b0; sel3 = 3'd3; end
      if (k == 4) load3 = 1'b0;
      push("scan0", 1'b0, 16'(1) << (k % 8), 1'b1, 4'(k % 8), (k % 8) == 0, 1'b0);
      tick();
    end

    // Enable dropped at idx=5, then direct load sel=2
    en3 = 1'b0;
    push("en_drop", 1'b0, 16'h0000, 1'b0, 4'd5, 1'b0, 1'b0); tick();
    en3 = 1'b1; load3 = 1'b1; mode3 = 1'b0; sel3 = 3'd2;
    push("reload", 1'b0, 16'h0004, 1'b1, 4'd2, 1'b0, 1'b1); tick();
    load3 = 1'b0;

    // Synchronous reset mid-scan at idx=4
    load3 = 1'b1; mode3 = 1'b1; sel3 = 3'd0; dwell3 = 4'd0;
    push("rscan_load", 1'b0, 16'h0001, 1'b1, 4'd0, 1'b0, 1'b0); tick();
    load3 = 1'b0;
    for (k = 1; k <= 4; k++) begin
      push("rscan", 1'b0, 16'(1) << k, 1'b1, 4'(k), 1'b0, 1'b0); tick();
    end
    rst_n = 1'b0;
    #2;
    push("rst_between", 1'b0, 16'h0010, 1'b1, 4'd4, 1'b0, 1'b0); compare_head();
    push("rst_edge", 1'b0, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b1); tick();
    rst_n = 1'b1;
    push("rst_idle", 1'b0, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b1); tick();

    // 16-output instance, dwell=1
`ifdef ONEHOT_DECODER_SEQ_SCAN_DIR_EN
    dir4 = 1'b1; sel4 = 4'd1;
    seq4 = '{1, 0, 0, 15, 15, 14};
`else
    sel4 = 4'd14;
    seq4 = '{14, 15, 15, 0, 0, 1};
`endif
    load4 = 1'b1; mode4 = 1'b1; dwell4 = 4'd1;
    push("w16_load", 1'b1, 16'(1) << sel4, 1'b1, sel4, 1'b0, 1'b0); tick();
    load4 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      push("w16_scan", 1'b1, 16'(1) << seq4[i], 1'b1, 4'(seq4[i]), i == 3, 1'b0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
